// File: rtl/spi_master_multi.sv
// Multi-slave SPI master: DATA_W words, runtime CPOL/CPHA/bit order, bursts.
// Optional SPI_MASTER_LOOPBACK_EN adds loopback_i (receive path taps mosi_o).
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DVSR_W = 16,
  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic              cont_i,
  input  logic [SS_W-1:0]   ss_sel_i,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback_i,
`endif
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [NUM_SS-1:0] ss_n_o,
  output logic [DATA_W-1:0] dout_o,
  output logic              ready_o,
  output logic              spi_done_tick_o
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SETUP      = 3'd1;
  localparam logic [2:0] SHIFT      = 3'd2;
  localparam logic [2:0] HOLD       = 3'd3;
  localparam logic [2:0] BURST_WAIT = 3'd4;

  localparam int HP_W = $clog2(2 * DATA_W);
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_W - 1);

  logic [2:0]        state_q;
  logic [DVSR_W-1:0] cnt_q;
  logic [DVSR_W-1:0] dvsr_q;
  logic [HP_W-1:0]   hp_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] tx_nxt;
  logic [DATA_W-1:0] rx_nxt;
  logic [DATA_W-1:0] dout_q;
  logic [NUM_SS-1:0] ss_q;
  logic [SS_W-1:0]   sel_q;
  logic              cpha_q;
  logic              lsb_q;
  logic              cont_q;
  logic              sclk_q;
  logic              tick_q;
  logic              cs_pend_q;
  logic              lb_q;
  logic              accept;
  logic              hp_end;
  logic              lead;
  logic              last_hp;
  logic              smp;
  logic              adv;
  logic              rx_bit;

  function automatic logic [NUM_SS-1:0] cs_dec(
    input logic [SS_W-1:0] s
  );
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (s == SS_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign ready_o = (state_q == IDLE) || (state_q == BURST_WAIT);
  assign accept  = start_i && ready_o;
  assign hp_end  = (state_q == SHIFT) && (cnt_q == '0);
  assign lead    = ~hp_q[0];
  assign last_hp = (hp_q == HP_LAST);

  // CPHA=1 presents bit 0 from setup, so the first leading edge never shifts
  assign smp = hp_end && (cpha_q ? ~lead : lead);
  assign adv = hp_end && (cpha_q ? (lead && hp_q != '0)
                                 : (~lead && !last_hp));

  assign mosi_o = lsb_q ? tx_q[0] : tx_q[DATA_W-1];

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = lb_q ? mosi_o : miso_i;
`else
  assign rx_bit = miso_i;
  assign lb_q   = 1'b0;
`endif

  always_comb begin
    rx_nxt = rx_q;
    tx_nxt = tx_q;
    if (smp) begin
      rx_nxt = lsb_q ? {rx_bit, rx_q[DATA_W-1:1]}
                     : {rx_q[DATA_W-2:0], rx_bit};
    end
    if (adv) begin
      tx_nxt = lsb_q ? {1'b0, tx_q[DATA_W-1:1]}
                     : {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvsr_q    <= '0;
      hp_q      <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      dout_q    <= '0;
      ss_q      <= '1;
      sel_q     <= '0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      cont_q    <= 1'b0;
      sclk_q    <= 1'b0;
      tick_q    <= 1'b0;
      cs_pend_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (accept) begin
        dvsr_q <= dvsr_i;
        cnt_q  <= dvsr_i;
        cpha_q <= cpha_i;
        lsb_q  <= lsb_first_i;
        cont_q <= cont_i;
        sel_q  <= ss_sel_i;
        sclk_q <= cpol_i;
        tx_q   <= din_i;
        hp_q   <= '0;
        if (state_q == BURST_WAIT && ss_sel_i == sel_q) begin
          state_q <= SHIFT;
        end else if (state_q == BURST_WAIT) begin
          // drop the old select for a cycle before the new one
          ss_q      <= '1;
          cs_pend_q <= 1'b1;
          state_q   <= SETUP;
        end else begin
          ss_q    <= cs_dec(ss_sel_i);
          state_q <= SETUP;
        end
      end else begin
        unique case (state_q)
          SETUP: begin
            if (cs_pend_q) begin
              cs_pend_q <= 1'b0;
              ss_q      <= cs_dec(sel_q);
            end else if (cnt_q == '0) begin
              cnt_q   <= dvsr_q;
              state_q <= SHIFT;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          SHIFT: begin
            if (hp_end) begin
              cnt_q  <= dvsr_q;
              sclk_q <= ~sclk_q;
              hp_q   <= hp_q + 1'b1;
              rx_q   <= rx_nxt;
              tx_q   <= tx_nxt;
              if (last_hp) begin
                dout_q  <= rx_nxt;
                tick_q  <= 1'b1;
                state_q <= cont_q ? BURST_WAIT : HOLD;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          HOLD: begin
            if (cnt_q == '0) begin
              ss_q    <= '1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_MASTER_LOOPBACK_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) lb_q <= 1'b0;
    else if (accept) lb_q <= loopback_i;
  end
`endif

  assign sclk_o          = sclk_q;
  assign ss_n_o          = ss_q;
  assign dout_o          = dout_q;
  assign spi_done_tick_o = tick_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with a behavioural SPI slave.
// Define SPI_MASTER_LOOPBACK_EN to also exercise the loopback path.
module tb_spi_master_multi;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  din_i;
  logic [15:0] dvsr_i;
  logic        cpol_i;
  logic        cpha_i;
  logic        lsb_first_i;
  logic        cont_i;
  logic [1:0]  ss_sel_i;
  logic        miso_i;
  logic        sclk_o;
  logic        mosi_o;
  logic [3:0]  ss_n_o;
  logic [7:0]  dout_o;
  logic        ready_o;
  logic        spi_done_tick_o;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic        loopback_i;
`endif

  int total = 0;
  int bad   = 0;

  logic        sl_armed = 1'b0;
  logic        sl_cpol  = 1'b0;
  logic        sl_cpha  = 1'b0;
  logic        sl_lsb   = 1'b0;
  logic        sl_tie0  = 1'b0;
  logic [7:0]  sl_words [4];
  logic [31:0] rec;
  logic [7:0]  cur;
  logic        sl_bit;
  int          lead_n, trail_n, rise_n, act_n, tick_n, ss1_hi, e;
  logic        burst_mon = 1'b0;

  spi_master_multi #(
    .DATA_W(8), .NUM_SS(4), .DVSR_W(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .din_i(din_i), .dvsr_i(dvsr_i), .cpol_i(cpol_i),
    .cpha_i(cpha_i), .lsb_first_i(lsb_first_i),
    .cont_i(cont_i), .ss_sel_i(ss_sel_i),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback_i(loopback_i),
`endif
    .miso_i(miso_i), .sclk_o(sclk_o), .mosi_o(mosi_o),
    .ss_n_o(ss_n_o), .dout_o(dout_o), .ready_o(ready_o),
    .spi_done_tick_o(spi_done_tick_o)
  );

  always #5 clk_i = ~clk_i;

  // slave: bit index follows the edge counts of the configured mode
  always_comb begin
    e = sl_cpha ? ((lead_n > 0) ? lead_n - 1 : 0) : trail_n;
    cur = sl_words[(e / 8) % 4];
    sl_bit = sl_lsb ? cur[e % 8] : cur[7 - (e % 8)];
  end
  assign miso_i = sl_tie0 ? 1'b0 : sl_bit;

  always @(sclk_o) begin
    if (sl_armed) begin
      if (sclk_o === 1'b1) rise_n++;
      if (sclk_o !== sl_cpol) begin
        lead_n++;
        if (!sl_cpha) rec = {rec[30:0], mosi_o};
      end else begin
        trail_n++;
        if (sl_cpha) rec = {rec[30:0], mosi_o};
      end
    end
  end

  always @(negedge clk_i) begin
    if (sl_armed && sclk_o !== sl_cpol) act_n++;
    if (spi_done_tick_o) tick_n++;
    if (burst_mon && ss_n_o[1]) ss1_hi++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic arm();
    lead_n = 0; trail_n = 0; rise_n = 0;
    act_n = 0; tick_n = 0; rec = '0;
    sl_armed = 1'b1;
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [7:0] d, input logic [15:0] dv,
                       input logic pol, input logic pha,
                       input logic lsb, input logic cnt,
                       input logic [1:0] sel);
    sl_cpol = pol; sl_cpha = pha; sl_lsb = lsb;
    din_i = d; dvsr_i = dv; cpol_i = pol; cpha_i = pha;
    lsb_first_i = lsb; cont_i = cnt; ss_sel_i = sel;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    while (spi_done_tick_o !== 1'b1 && n < maxc) begin
      @(negedge clk_i);
      n++;
    end
    chk("tick_seen", 32'(spi_done_tick_o), 32'd1);
  endtask

  task automatic wait_rise(input int k);
    int n;
    n = 0;
    while (rise_n < k && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    chk("rise_reached", 32'(rise_n >= k), 32'd1);
  endtask

  initial begin
    int n;
    rst_ni = 1'b0; start_i = 1'b0; din_i = '0; dvsr_i = '0;
    cpol_i = 1'b0; cpha_i = 1'b0; lsb_first_i = 1'b0;
    cont_i = 1'b0; ss_sel_i = '0;
`ifdef SPI_MASTER_LOOPBACK_EN
    loopback_i = 1'b0;
`endif
    sl_words[0] = 8'h00; sl_words[1] = 8'h00;
    sl_words[2] = 8'h00; sl_words[3] = 8'h00;
    rec = '0;
    lead_n = 0; trail_n = 0; rise_n = 0;
    act_n = 0; tick_n = 0; ss1_hi = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_ss", 32'(ss_n_o), 32'hF);
    chk("rst_sclk", 32'(sclk_o), 32'd0);
    chk("rst_mosi", 32'(mosi_o), 32'd0);
    chk("rst_dout", 32'(dout_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_tick", 32'(spi_done_tick_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // mode 0, MSB first, dvsr=3
    sl_words[0] = 8'h23;
    issue(8'hA5, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    arm();
    chk("m0_ready_low", 32'(ready_o), 32'd0);
    chk("m0_ss", 32'(ss_n_o), 32'hE);
    chk("m0_sclk_idle", 32'(sclk_o), 32'd0);
    chk("m0_first_mosi", 32'(mosi_o), 32'd1);
    wait_tick(400, n);
    chk("m0_dout", 32'(dout_o), 32'h23);
    chk("m0_ss_at_tick", 32'(ss_n_o), 32'hE);
    repeat (3) @(negedge clk_i);
    chk("m0_ss_hold", 32'(ss_n_o), 32'hE);
    @(negedge clk_i);
    chk("m0_ss_release", 32'(ss_n_o), 32'hF);
    chk("m0_ready_back", 32'(ready_o), 32'd1);
    chk("m0_mosi_seq", rec & 32'hFF, 32'hA5);
    chk("m0_rises", 32'(rise_n), 32'd8);
    chk("m0_active_cyc", 32'(act_n), 32'd32);
    chk("m0_ticks", 32'(tick_n), 32'd1);
    sl_armed = 1'b0;

    // mode 3, LSB first, dvsr=0, ss 2
    sl_words[0] = 8'hC3;
    issue(8'h3C, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
    arm();
    chk("m3_ss", 32'(ss_n_o), 32'hB);
    chk("m3_sclk_idle", 32'(sclk_o), 32'd1);
    wait_tick(100, n);
    chk("m3_dout", 32'(dout_o), 32'hC3);
    chk("m3_sclk_end", 32'(sclk_o), 32'd1);
    @(negedge clk_i);
    chk("m3_ss_release", 32'(ss_n_o), 32'hF);
    chk("m3_mosi_seq", rec & 32'hFF, 32'h3C);
    chk("m3_rises", 32'(rise_n), 32'd8);
    chk("m3_active_cyc", 32'(act_n), 32'd8);
    sl_armed = 1'b0;

    // burst of three words on ss 1, dvsr=1
    sl_words[0] = 8'hA1; sl_words[1] = 8'hB2; sl_words[2] = 8'hC3;
    issue(8'h11, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    arm();
    ss1_hi = 0;
    burst_mon = 1'b1;
    wait_tick(200, n);
    chk("b1_dout", 32'(dout_o), 32'hA1);
    chk("b1_ready", 32'(ready_o), 32'd1);
    issue(8'h22, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    wait_tick(200, n);
    chk("b2_gap", 32'(n), 32'd32);
    chk("b2_dout", 32'(dout_o), 32'hB2);
    issue(8'h33, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    wait_tick(200, n);
    burst_mon = 1'b0;
    chk("b3_gap", 32'(n), 32'd32);
    chk("b3_dout", 32'(dout_o), 32'hC3);
    repeat (2) @(negedge clk_i);
    chk("b_ss_release", 32'(ss_n_o), 32'hF);
    chk("b_ss1_held", 32'(ss1_hi), 32'd0);
    chk("b_mosi_seq", rec & 32'hFFFFFF, 32'h112233);
    chk("b_rises", 32'(rise_n), 32'd24);
    chk("b_ticks", 32'(tick_n), 32'd3);
    sl_armed = 1'b0;

    // reset after three bits of a mode 0 word
    sl_words[0] = 8'h23;
    issue(8'hA5, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    arm();
    wait_rise(3);
    sl_armed = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("ra_ss", 32'(ss_n_o), 32'hF);
    chk("ra_sclk", 32'(sclk_o), 32'd0);
    chk("ra_ready", 32'(ready_o), 32'd1);
    chk("ra_tick", 32'(spi_done_tick_o), 32'd0);
    @(negedge clk_i);
    chk("ra_dout", 32'(dout_o), 32'd0);
    rst_ni = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("ra_no_tick", 32'(tick_n), 32'd0);
    sl_words[0] = 8'h5C;
    issue(8'h96, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    arm();
    wait_tick(400, n);
    chk("ra_again_dout", 32'(dout_o), 32'h5C);
    repeat (4) @(negedge clk_i);
    chk("ra_again_mosi", rec & 32'hFF, 32'h96);
    sl_armed = 1'b0;

    // start during SHIFT is dropped
    sl_words[0] = 8'h81;
    issue(8'h4E, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    arm();
    wait_rise(2);
    chk("ig_busy", 32'(ready_o), 32'd0);
    din_i = 8'hFF;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_tick(400, n);
    chk("ig_dout", 32'(dout_o), 32'h81);
    repeat (15) @(negedge clk_i);
    chk("ig_ss_idle", 32'(ss_n_o), 32'hF);
    chk("ig_ready", 32'(ready_o), 32'd1);
    chk("ig_ticks", 32'(tick_n), 32'd1);
    chk("ig_mosi", rec & 32'hFF, 32'h4E);
    sl_armed = 1'b0;

`ifdef SPI_MASTER_LOOPBACK_EN
    sl_tie0 = 1'b1;
    loopback_i = 1'b1;
    issue(8'h5A, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    loopback_i = 1'b0;
    arm();
    wait_tick(200, n);
    chk("lb_dout", 32'(dout_o), 32'h5A);
    sl_armed = 1'b0;
    sl_tie0 = 1'b0;
    repeat (4) @(negedge clk_i);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
- Parametrised next-generation SPI master for the SPI IP.
- Generalises the single-byte, single-slave master to:
  - configurable word width DATA_W;
  - NUM_SS chip selects;
  - runtime CPOL/CPHA and bit order;
  - back-to-back burst words with chip select held asserted.
- Sits between a register/bus front end (start/ready handshake) and external SPI pins.

Parameters:
- DATA_W, 8: bits per transfer word (4..32).
- NUM_SS, 4: number of active-low chip-select outputs (1..16).
- DVSR_W, 16: width of the clock-divider input.

Ports:
- clk_i  input  1  system clock, single clock domain.
- rst_ni  input  1  synchronous active-low reset.
- start_i  input  1  transfer request; accepted only when ready_o=1.
- din_i  input  DATA_W  word to transmit, captured on accept.
- dvsr_i  input  DVSR_W  SCLK half-period = dvsr_i+1 clk_i cycles, captured on accept.
- cpol_i  input  1  SCLK idle level, captured on accept.
- cpha_i  input  1  clock phase, captured on accept.
- lsb_first_i  input  1  1 = LSB shifted first, captured on accept.
- cont_i  input  1  1 = keep chip select asserted after this word, captured on accept.
- ss_sel_i  input  $clog2(NUM_SS) (min 1)  chip-select index, captured on accept.
- miso_i  input  1  serial data from slave.
- sclk_o  output  1  SPI clock.
- mosi_o  output  1  serial data to slave.
- ss_n_o  output  NUM_SS  active-low chip selects; at most one low.
- dout_o  output  DATA_W  last received word.
- ready_o  output  1  able to accept start_i.
- spi_done_tick_o  output  1  one-cycle pulse when a word completes.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - state=IDLE, sclk_o=0, mosi_o=0, ss_n_o=all 1, dout_o=0, ready_o=1, spi_done_tick_o=0.
  - Reset mid-transfer aborts immediately; no done tick is issued.
- States: IDLE, SETUP, SHIFT, HOLD, BURST_WAIT.
- Accept: start_i=1 and ready_o=1 at a clk_i edge. All *_i configuration is registered then; later changes have no effect until the next accept.
- IDLE -> SETUP on accept:
  - ready_o drops the next cycle.
  - ss_n_o[sel] goes low the next cycle.
  - sclk_o is held at captured cpol.
  - mosi_o is driven with the first bit (MSB, or LSB if lsb_first).
- SETUP: lasts dvsr+1 cycles, then SHIFT.
- SHIFT: 2*DATA_W half-periods, each dvsr+1 cycles; sclk_o toggles at each half-period boundary.
  - CPHA=0: miso sampled on the leading edge; mosi advances on the trailing edge (no advance after the last bit).
  - CPHA=1: mosi advances on the leading edge (first bit presented at the first leading edge); miso sampled on the trailing edge.
- End of the last half-period:
  - dout_o updated with the assembled word, in the same bit order as transmit.
  - spi_done_tick_o=1 for exactly one cycle.
  - sclk_o back at cpol.
- After a word with cont=0: HOLD for dvsr+1 cycles, then ss_n_o all 1, ready_o=1, IDLE.
- After a word with cont=1: BURST_WAIT.
  - ss_n_o stays low and ready_o=1.
  - A new accept goes directly to SHIFT with no SETUP; the new configuration is captured. A differing ss_sel_i first deasserts the old CS, then runs SETUP on the new one.
  - A new word issued with cont=0 ends the burst normally.
- start_i while ready_o=0 is ignored, not queued.
- Edge cases:
  - dvsr_i=0 gives the fastest mode, SCLK = clk_i/2.
  - ss_sel_i >= NUM_SS: the transfer runs with all ss_n_o high.
- Divider counter wraps only through reload; no free-running counter exists in IDLE.

Optional Feature:
- Macro SPI_MASTER_LOOPBACK_EN.
- Defined: adds input loopback_i, captured on accept. When it is 1, the internal receive path samples mosi_o instead of miso_i, so dout_o equals the transmitted word. Pins behave unchanged.
- Undefined: the port is absent and the receive path always uses miso_i.

Test Plan:
- Mode 0, MSB first, dvsr=3, din=0xA5, slave returns 0x23:
  - mosi sequence 1,0,1,0,0,1,0,1.
  - 8 rising sclk edges, 4 clk_i per half-period.
  - dout_o=0x23, one done tick, ss_n_o[0] high 4 cycles after the tick.
- Mode 3 (cpol=1, cpha=1), lsb_first=1, dvsr=0, din=0x3C, ss_sel=2:
  - sclk idles high; mosi 0,0,1,1,1,1,0,0 on falling edges.
  - Only ss_n_o[2] low; dout_o matches slave 0xC3 in LSB order.
- Burst 0x11 (cont=1), 0x22 (cont=1), 0x33 (cont=0) on ss 1:
  - ss_n_o[1] stays low across all three words.
  - Three done ticks; no SETUP gap between words.
- Reset asserted mid-SHIFT after 3 bits:
  - Next edge gives ss_n_o all 1, sclk_o=cpol reset value 0, ready_o=1, no done tick.
  - A following transfer completes correctly.
- start_i pulsed during SHIFT with din=0xFF:
  - Ignored; the current word completes and only one done tick is seen.
- With SPI_MASTER_LOOPBACK_EN, loopback_i=1, din=0x5A, miso_i tied 0:
  - dout_o=0x5A.
